// File: rtl/input_pixel_queue.sv
// Input stage of the network: binarises a serial 28x28 image against a threshold
// and queues the index of every active pixel, then serves those indices to Layer 1.
module input_pixel_queue #(
   parameter int NUM_PIXELS  = 784,
   parameter int ADDR_WIDTH  = 10,
   parameter int PIXEL_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [PIXEL_WIDTH-1:0] pixelIn,
   input  logic                   pixelValid,
   input  logic [PIXEL_WIDTH-1:0] threshold,
   output logic                   pixelReady,
   input  logic                   dequeue,
   output logic [ADDR_WIDTH-1:0]  queueOut,
   output logic                   queueEmpty,
   output logic                   inputsReady,
   output logic [ADDR_WIDTH-1:0]  activeCount,
   output logic                   emptyImage
);

   typedef enum logic {LOAD, SERVE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_PIXEL = ADDR_WIDTH'(NUM_PIXELS - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

   state_t                 r_state;
   logic [ADDR_WIDTH-1:0]  r_pixCount;
   logic [ADDR_WIDTH-1:0]  r_wrPtr;
   logic [ADDR_WIDTH-1:0]  r_rdPtr;
   logic [PIXEL_WIDTH-1:0] r_threshold;
   logic                   r_emptyImage;
   logic [ADDR_WIDTH-1:0]  r_mem [NUM_PIXELS];

   logic                   w_accept;
   logic [PIXEL_WIDTH-1:0] w_thr;
   logic                   w_active;
   logic                   w_lastPixel;
   logic                   w_ptrsEqual;

   // Pixel 0 is compared against the live input because the capture lands on the same edge.
   assign w_accept    = pixelValid && (r_state == LOAD);
   assign w_thr       = (r_pixCount == '0) ? threshold : r_threshold;
   assign w_active    = (pixelIn >= w_thr);
   assign w_lastPixel = (r_pixCount == LAST_PIXEL);
   assign w_ptrsEqual = (r_rdPtr == r_wrPtr);

   assign pixelReady  = (r_state == LOAD);
   assign inputsReady = (r_state == SERVE);
   assign queueEmpty  = (r_state == LOAD) || w_ptrsEqual;
   assign queueOut    = queueEmpty ? '0 : r_mem[r_rdPtr];
   assign activeCount = r_wrPtr;
   assign emptyImage  = r_emptyImage;

   always_ff @(posedge clk) begin
      if (w_accept && w_active) begin
         r_mem[r_wrPtr] <= r_pixCount;
      end
   end

   // The write pointer doubles as the active-pixel count, since every active pixel gets one slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= LOAD;
         r_pixCount   <= '0;
         r_wrPtr      <= '0;
         r_rdPtr      <= '0;
         r_threshold  <= '0;
         r_emptyImage <= 1'b0;
      end else begin
         r_emptyImage <= 1'b0;
         if (r_state == LOAD) begin
            if (w_accept) begin
               if (r_pixCount == '0) begin
                  r_threshold <= threshold;
               end
               r_pixCount <= r_pixCount + ONE;
               if (w_active) begin
                  r_wrPtr <= r_wrPtr + ONE;
               end
               if (w_lastPixel) begin
                  if (w_active || (r_wrPtr != '0)) begin
                     r_state <= SERVE;
                  end else begin
                     r_emptyImage <= 1'b1;
                     r_pixCount   <= '0;
                     r_wrPtr      <= '0;
                     r_rdPtr      <= '0;
                  end
               end
            end
         end else begin
            // One cycle of inputsReady with an empty queue lets Layer 1 see the image end.
            if (w_ptrsEqual) begin
               r_state    <= LOAD;
               r_pixCount <= '0;
               r_wrPtr    <= '0;
               r_rdPtr    <= '0;
            end else if (dequeue) begin
               r_rdPtr <= r_rdPtr + ONE;
            end
         end
      end
   end

endmodule
